diff_freq_packet_tx: RTL
========================

Name: diff_freq_packet_tx

Overview:
Host-side packet builder for the diff_freq_serial_out command channel. It takes one parallel command and streams it, one byte at a time, into the UART transmitter using the tx_start/tx_done handshake:
- output pattern
- frequency pattern
- control byte
- slow period
- fast period

It lets an on-chip sequencer or a loopback tester drive the pattern generator over the same serial link a PC would use.

Parameters:
DATA_BIT, 32, width of out_pattern and freq_pattern; must be a multiple of 8.
PACK_NUM, (DATA_BIT/8)*2+3, number of bytes per packet (11 at default).
GAP_CLK, 0, idle clocks inserted between a byte's tx_done_tick_i and the next tx_start_o; 0..65535.
CMD_CODE, 2'b01, value placed in control byte bits [1:0].

Ports:
clk_i  input  1  system clock
rst_ni  input  1  asynchronous active-low reset
start_i  input  1  request to send one packet; sampled only in IDLE
out_pattern_i  input  DATA_BIT  output bit pattern
freq_pattern_i  input  DATA_BIT  per-bit frequency select (1 = fast)
channel_i  input  4  target serial output channel
mode_i  input  1  0 = one-shot, 1 = repeat
slow_period_i  input  8  slow bit period in clocks
fast_period_i  input  8  fast bit period in clocks
tx_start_o  output  1  one-clock pulse to the UART tx_start_i
tx_data_o  output  8  byte to the UART tx_data_i
tx_done_tick_i  input  1  UART tx_done_tick_o
busy_o  output  1  high from the cycle after start_i is accepted until done_tick_o
done_tick_o  output  1  one-clock pulse when the last byte has completed

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous, active-low on rst_ni.
- Reset values: tx_start_o=0, tx_data_o=8'h00, busy_o=0, done_tick_o=0, state=IDLE, byte index=0, gap counter=0.
- Packet byte order:
  - Bytes 0..3: out_pattern, LSB byte first.
  - Bytes 4..7: freq_pattern, LSB byte first.
  - Byte 8: control = {channel[3:0], 1'b0, mode, CMD_CODE[1:0]}.
  - Byte 9: slow_period.
  - Byte 10: fast_period.
- Capture: on the edge where start_i=1 in IDLE, all inputs are registered into a PACK_NUM×8 shift register. Later input changes do not affect the packet in flight.
- States:
  - IDLE: start_i → SEND.
  - SEND: assert tx_start_o for one cycle with tx_data_o = current byte → WAIT.
  - WAIT: tx_data_o held stable. On tx_done_tick_i: if last byte → DONE; else if GAP_CLK=0 → SEND; else → GAP.
  - GAP: count GAP_CLK cycles → SEND.
  - DONE: done_tick_o=1 for one cycle, busy_o=0 → IDLE.
- Latency:
  - First tx_start_o is asserted in the cycle after start_i is sampled.
  - With GAP_CLK=0, the next tx_start_o is asserted the cycle after tx_done_tick_i is sampled.
  - With GAP_CLK=N, exactly N cycles separate the tx_done_tick_i sample and the next tx_start_o.
- Byte index: 4-bit counter (sized to clog2(PACK_NUM)). Advances on each accepted tx_done_tick_i. Resets to 0 in DONE. Never wraps mid-packet.
- start_i while busy: ignored, not queued. start_i in the DONE cycle is also ignored; it is accepted from IDLE only.
- tx_done_tick_i outside WAIT (IDLE, SEND, GAP, DONE): ignored, with no state change.
- Back-to-back operation: start_i held high continuously starts a new packet in the cycle after returning to IDLE. Minimum spacing is one IDLE cycle between packets.
- Reset mid-packet: the packet is abandoned immediately and all outputs return to reset values. No done_tick_o is issued for the aborted packet.

Test Plan:
- Basic packet: out=32'h55555555, freq=0, ch=0, mode=0, slow=8'h14, fast=8'h05, GAP_CLK=0 → UART sees 55 55 55 55 00 00 00 00 01 14 05, then one done_tick_o.
- Byte order and control byte: out=32'h11223344, freq=32'hA5A5F00F, ch=13, mode=1 → bytes 44 33 22 11 0F F0 A5 A5 D5 then slow/fast; exactly 11 tx_start_o pulses.
- Gap timing: GAP_CLK=7 with an ideal tx_done_tick_i returned 3 cycles after each tx_start_o → exactly 7 cycles between each done tick and the next start; busy_o stays high throughout.
- Ignored events: start_i pulsed mid-packet and spurious tx_done_tick_i in IDLE/GAP → packet contents and count unchanged; no extra packet is sent.
- Reset abort: rst_ni low after byte 5 → all outputs 0 asynchronously. A new start_i after reset sends a complete 11-byte packet from byte 0.
- Loopback with UART and diff_freq_serial_out: channels 0..15, repeat mode on 1/5/9/13 → the selected channel outputs pattern 0101… at slow period 20 clocks.

Source files
------------

// File: rtl/diff_freq_packet_tx.sv
// diff_freq_packet_tx: serialises one parallel pattern command into UART bytes over tx_start/tx_done
//   clk_i          system clock
//   rst_ni         asynchronous active-low reset
//   start_i        request one packet (accepted in IDLE only)
//   out_pattern_i  output bit pattern, sent LSB byte first
//   freq_pattern_i per-bit frequency select, sent LSB byte first
//   channel_i      target channel, control byte [7:4]
//   mode_i         0 one-shot / 1 repeat, control byte [2]
//   slow_period_i  slow bit period byte
//   fast_period_i  fast bit period byte
//   tx_start_o     one-clock start pulse to the UART
//   tx_data_o      byte to the UART, stable while it transmits
//   tx_done_tick_i UART byte-complete pulse
//   busy_o         packet in flight
//   done_tick_o    one-clock pulse after the last byte completes
module diff_freq_packet_tx #(
    parameter int         DATA_BIT = 32,
    parameter int         PACK_NUM = (DATA_BIT / 8) * 2 + 3,
    parameter int         GAP_CLK  = 0,
    parameter logic [1:0] CMD_CODE = 2'b01
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic [DATA_BIT-1:0] out_pattern_i,
    input  logic [DATA_BIT-1:0] freq_pattern_i,
    input  logic [3:0]          channel_i,
    input  logic                mode_i,
    input  logic [7:0]          slow_period_i,
    input  logic [7:0]          fast_period_i,
    output logic                tx_start_o,
    output logic [7:0]          tx_data_o,
    input  logic                tx_done_tick_i,
    output logic                busy_o,
    output logic                done_tick_o
);
    localparam int              IDX_W    = $clog2(PACK_NUM);
    localparam int              SR_W     = PACK_NUM * 8;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PACK_NUM - 1);
    localparam logic [15:0]     GAP_LAST = (GAP_CLK > 0) ? 16'(GAP_CLK - 1) : 16'd0;

    typedef enum logic [2:0] {IDLE, SEND, WAIT, GAP, DONE} state_t;

    state_t           state_q, state_d;
    logic [SR_W-1:0]  sr_q, sr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [15:0]      gap_q, gap_d;
    logic [7:0]       ctrl;

    assign ctrl = {channel_i, 1'b0, mode_i, CMD_CODE};

    // The current byte always sits in the low byte of the shift register;
    // it is zero after reset and after the final shift of a packet.
    assign tx_data_o   = sr_q[7:0];
    assign tx_start_o  = state_q == SEND;
    assign busy_o      = state_q == SEND || state_q == WAIT || state_q == GAP;
    assign done_tick_o = state_q == DONE;

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        case (state_q)
            IDLE: if (start_i) begin
                state_d = SEND;
                sr_d    = SR_W'({fast_period_i, slow_period_i, ctrl, freq_pattern_i, out_pattern_i});
                idx_d   = '0;
            end
            SEND: state_d = WAIT;
            WAIT: if (tx_done_tick_i) begin
                sr_d  = sr_q >> 8;
                idx_d = idx_q + 1'b1;
                gap_d = 16'd0;
                state_d = (idx_q == LAST_IDX) ? DONE : (GAP_CLK == 0) ? SEND : GAP;
            end
            GAP: begin
                gap_d   = (gap_q == GAP_LAST) ? 16'd0 : gap_q + 16'd1;
                state_d = (gap_q == GAP_LAST) ? SEND : GAP;
            end
            DONE: begin
                state_d = IDLE;
                idx_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            sr_q    <= '0;
            idx_q   <= '0;
            gap_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
        end
    end
endmodule
